pipelined_dual_port_ram: RTL
============================

# pipelined_dual_port_ram

Single-clock simple dual-port RAM with one write port and one read port. Generalises the earlier dual-port memory with per-lane write masking, a configurable read pipeline depth, a read-valid strobe and a selectable read-during-write policy. Used as the storage array behind FIFOs, line buffers and register files that need a registered, timing-friendly read path in a single clock domain.

## Interface
- WIDTH, 32, data word width; must be a multiple of LANE_WIDTH
- DEPTH, 16, number of words; any value ≥ 2, power of two not required
- ADDRESS_WIDTH, `CLOG2(DEPTH)`, address width
- LANE_WIDTH, 8, bits per write-mask lane
- LANES, WIDTH/LANE_WIDTH, derived lane count
- READ_LATENCY, 1, cycles from accepted read to data; legal range 1..4
- WRITE_FIRST, 0, same-address read-during-write policy: 0 = old data, 1 = new data
- clock  input  1  single clock, all logic on rising edge
- resetn  input  1  reset, synchronous, active-low
- write_enable  input  1  write strobe
- write_address  input  ADDRESS_WIDTH  write word address
- write_data  input  WIDTH  write data
- write_mask  input  LANES  per-lane write enable; bit i covers bits [i*LANE_WIDTH +: LANE_WIDTH]
- read_enable  input  1  read strobe
- read_address  input  ADDRESS_WIDTH  read word address
- read_data  output  WIDTH  read data
- read_valid  output  1  one-cycle pulse, read_data carries result of a read
- write_parity_invert  input  1  parity fault injection (only with PIPELINED_DUAL_PORT_RAM_PARITY_EN)
- read_parity_error  output  1  parity mismatch flag (only with PIPELINED_DUAL_PORT_RAM_PARITY_EN)

## Operation
- Reset (resetn low at a rising edge): all memory words cleared to 0, all pipeline stages invalidated and zeroed; read_data = 0, read_valid = 0, read_parity_error = 0. Reset overrides any write/read in the same cycle. Reads in flight when reset asserts are discarded; no read_valid is produced for them.
- Write: write_enable high at edge → lanes with write_mask[i]=1 updated, others retained. write_enable with write_mask = 0 is a no-op. write_address ≥ DEPTH: write ignored.
- Read: read_enable high at edge → word at read_address captured into stage 1 with valid bit set. Stages shift every cycle unconditionally (no stall). read_address ≥ DEPTH: read_data returns 0, read_valid still pulses.
- Read-during-write, same address, same cycle: WRITE_FIRST=0 returns pre-write word; WRITE_FIRST=1 returns the merged word (masked lanes new, unmasked lanes old). Different addresses: no interaction.
- read_data holds its last valid value while read_valid is low; it only updates on the cycle read_valid rises.
- Back-to-back reads every cycle supported; one result per cycle, in order.

## Timing
- Read accepted at edge N → read_data/read_valid valid after edge N+READ_LATENCY-1, i.e. observable in cycle N+READ_LATENCY relative to request cycle N. READ_LATENCY=1: registered output directly from array.
- Write at edge N visible to a read issued at edge N+1 (any policy); visible at edge N only with WRITE_FIRST=1.
- read_valid is exactly a delayed copy of read_enable (gated by reset), latency READ_LATENCY.
- read_parity_error aligned with read_data, asserted only together with read_valid.

## Configuration
- PIPELINED_DUAL_PORT_RAM_PARITY_EN defined: one even-parity bit stored per lane; computed on write for written lanes (inverted when write_parity_invert is high); checked on read; read_parity_error = OR of lane mismatches, travels through the pipeline with the data. Reset clears parity bits to 0 (consistent with zero data). Same-address WRITE_FIRST bypass forwards the parity bits being written.
- Not defined: no parity storage, write_parity_invert and read_parity_error ports absent.

## Test plan
- Reset then read address 3, READ_LATENCY=2 → read_valid pulses exactly 2 cycles later, read_data = 0x00000000.
- Write 0xAABBCCDD to address 5 mask 0xF, then write 0x11223344 mask 0x5 → read address 5 returns 0xAA22CC44.
- Same cycle write 0x12345678 / read address 7 (held 0xDEADBEEF): WRITE_FIRST=0 → 0xDEADBEEF; WRITE_FIRST=1 → 0x12345678.
- Continuous reads of addresses 0..15 with READ_LATENCY=4 → 16 consecutive read_valid pulses, data in order; resetn low mid-stream → no further read_valid, read_data = 0.
- Parity enabled: write 0x000000FF to address 2 with write_parity_invert=1 → read returns 0x000000FF with read_parity_error=1; rewrite without inversion → read_parity_error=0.
- DEPTH=12: write to address 13 ignored; read address 13 → read_data 0, read_valid 1; addresses 0..11 unchanged.

Source files
------------

// File: rtl/pipelined_dual_port_ram.sv
// Single-clock simple dual-port RAM: masked write port, pipelined read port with valid strobe.
// Define PIPELINED_DUAL_PORT_RAM_PARITY_EN to add per-lane even parity with fault injection.
module pipelined_dual_port_ram #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int LANE_WIDTH    = 8,
  parameter int LANES         = WIDTH / LANE_WIDTH,
  parameter int READ_LATENCY  = 1,
  parameter int WRITE_FIRST   = 0
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     write_enable,
  input  logic [ADDRESS_WIDTH-1:0] write_address,
  input  logic [WIDTH-1:0]         write_data,
  input  logic [LANES-1:0]         write_mask,
  input  logic                     read_enable,
  input  logic [ADDRESS_WIDTH-1:0] read_address,
  output logic [WIDTH-1:0]         read_data,
  output logic                     read_valid
`ifdef PIPELINED_DUAL_PORT_RAM_PARITY_EN
  ,
  input  logic                     write_parity_invert,
  output logic                     read_parity_error
`endif
);

  localparam logic [ADDRESS_WIDTH:0] DEPTH_LIM = DEPTH[ADDRESS_WIDTH:0];

  function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] old_word,
                                                   input logic [WIDTH-1:0] new_word,
                                                   input logic [LANES-1:0] mask);
    logic [WIDTH-1:0] res;
    res = old_word;
    for (int l = 0; l < LANES; l++)
      if (mask[l]) res[l*LANE_WIDTH +: LANE_WIDTH] = new_word[l*LANE_WIDTH +: LANE_WIDTH];
    return res;
  endfunction

  function automatic logic [LANES-1:0] lane_parity(input logic [WIDTH-1:0] word);
    logic [LANES-1:0] p;
    for (int l = 0; l < LANES; l++) p[l] = ^word[l*LANE_WIDTH +: LANE_WIDTH];
    return p;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;
  logic             rd_ok;
  logic             bypass;
  logic [WIDTH-1:0] rd_word;

  assign wr_ok  = write_enable && ({1'b0, write_address} < DEPTH_LIM);
  assign rd_ok  = {1'b0, read_address} < DEPTH_LIM;
  // Same-address forwarding only exists under the new-data policy.
  assign bypass = (WRITE_FIRST != 0) && wr_ok && (write_address == read_address);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[write_address] <= merge_lanes(mem[write_address], write_data, write_mask);
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_ok)
      rd_word = bypass ? merge_lanes(mem[read_address], write_data, write_mask)
                       : mem[read_address];
  end

`ifdef PIPELINED_DUAL_PORT_RAM_PARITY_EN
  logic [LANES-1:0] par_mem [DEPTH];
  logic [LANES-1:0] wr_par;
  logic [LANES-1:0] rd_par;
  logic             rd_err;

  assign wr_par = lane_parity(write_data) ^ {LANES{write_parity_invert}};

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) par_mem[i] <= '0;
    end else if (wr_ok) begin
      par_mem[write_address] <= (par_mem[write_address] & ~write_mask) | (wr_par & write_mask);
    end
  end

  always_comb begin
    rd_par = '0;
    if (rd_ok)
      rd_par = bypass ? ((par_mem[read_address] & ~write_mask) | (wr_par & write_mask))
                      : par_mem[read_address];
  end

  assign rd_err = |(rd_par ^ lane_parity(rd_word));
`endif

  // ---- read pipeline: stage 0 captures from the array, last stage drives the outputs
  logic [WIDTH-1:0]        data_p [READ_LATENCY];
  logic [READ_LATENCY-1:0] vld_p;

  // Data registers only load alongside a valid bit, so read_data holds between results.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      vld_p <= '0;
      for (int k = 0; k < READ_LATENCY; k++) data_p[k] <= '0;
    end else begin
      vld_p[0] <= read_enable;
      if (read_enable) data_p[0] <= rd_word;
      for (int k = 1; k < READ_LATENCY; k++) begin
        vld_p[k] <= vld_p[k-1];
        if (vld_p[k-1]) data_p[k] <= data_p[k-1];
      end
    end
  end

  assign read_data  = data_p[READ_LATENCY-1];
  assign read_valid = vld_p[READ_LATENCY-1];

`ifdef PIPELINED_DUAL_PORT_RAM_PARITY_EN
  logic [READ_LATENCY-1:0] err_p;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      err_p <= '0;
    end else begin
      err_p[0] <= read_enable & rd_err;
      for (int k = 1; k < READ_LATENCY; k++) err_p[k] <= vld_p[k-1] & err_p[k-1];
    end
  end

  assign read_parity_error = err_p[READ_LATENCY-1];
`endif

endmodule
